// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and default width.
package univ_shift_reg_pkg;

  localparam int unsigned USR_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } usr_mode_e;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control, data and status signals of the universal shift register.
interface univ_shift_reg_if #(
  parameter int unsigned WIDTH = 4
);
  logic             En;
  logic [1:0]       S;
  logic             SIR;
  logic             SIL;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic             SOR;
  logic             SOL;
  logic             Zero;

  modport master (
    output En, S, SIR, SIL, D,
    input  Q, Qbar, SOR, SOL, Zero
  );

  modport slave (
    input  En, S, SIR, SIL, D,
    output Q, Qbar, SOR, SOL, Zero
  );
endinterface

// File: rtl/univ_shift_reg_d_ff_ms.sv
// Master-slave D flip-flop built from two level-sensitive latches on opposite clock phases,
// with an asynchronous active-low clear that forces both latches to zero.
module d_ff_ms (
  input  logic Clk,
  input  logic Rst_n,
  input  logic D,
  output logic Q,
  output logic Qbar
);

  logic r_master;
  logic r_slave;

  // Master is open while Clk is low, so D is frozen at the rising edge.
  always_latch begin
    if (!Rst_n) begin
      r_master <= 1'b0;
    end else if (!Clk) begin
      r_master <= D;
    end
  end

  always_latch begin
    if (!Rst_n) begin
      r_slave <= 1'b0;
    end else if (Clk) begin
      r_slave <= r_master;
    end
  end

  assign Q    = r_slave;
  assign Qbar = ~r_slave;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: hold, shift right, shift left and parallel load,
// one master-slave flip-flop per bit behind a 4:1 next-state mux gated by En.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = USR_WIDTH_DEFAULT
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  univ_shift_reg_if.slave        bus
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qbar;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = w_q;
    if (bus.En) begin
      case (bus.S)
        MODE_HOLD: w_next = w_q;
        MODE_SHR:  w_next = {bus.SIR, w_q[WIDTH-1:1]};
        MODE_SHL:  w_next = {w_q[WIDTH-2:0], bus.SIL};
        MODE_LOAD: w_next = bus.D;
        default:   w_next = w_q;
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    d_ff_ms u_ff (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .D     (w_next[g]),
      .Q     (w_q[g]),
      .Qbar  (w_qbar[g])
    );
  end

  // Status outputs are pure decodes of the flip-flop outputs, so SOR/SOL can loop back to SIR/SIL.
  assign bus.Q    = w_q;
  assign bus.Qbar = w_qbar;
  assign bus.SOR  = w_q[0];
  assign bus.SOL  = w_q[WIDTH-1];
  assign bus.Zero = ~|w_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=4.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  localparam int unsigned W = 4;

  logic Clk;
  logic Rst_n;
  logic r_sir;
  logic r_ring;
  logic r_johnson;
  int   n_chk;
  int   n_err;

  univ_shift_reg_if #(.WIDTH(W)) bus ();

  univ_shift_reg #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  assign bus.SIR = r_ring ? bus.SOR : (r_johnson ? ~bus.SOR : r_sir);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle inside the high phase.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] val);
    bus.En = 1'b1;
    bus.S  = MODE_LOAD;
    bus.D  = val;
    tick();
  endtask

  logic [W-1:0] exp_seq [8];
  logic         exp_sor [3];

  initial begin
    n_chk = 0; n_err = 0;
    r_sir = 1'b0; r_ring = 1'b0; r_johnson = 1'b0;
    bus.En = 1'b0; bus.S = MODE_HOLD; bus.SIL = 1'b0; bus.D = '0;
    Rst_n = 1'b0;
    #12;
    chk("rst_q",    16'(bus.Q),    16'h0);
    chk("rst_qbar", 16'(bus.Qbar), 16'hF);
    chk("rst_zero", 16'(bus.Zero), 16'h1);
    chk("rst_sor",  16'(bus.SOR),  16'h0);
    chk("rst_sol",  16'(bus.SOL),  16'h0);

    // Mid-cycle reset with Q=1011, then reset-held edges ignored.
    @(negedge Clk);
    Rst_n = 1'b1;
    load(4'b1011);
    chk("load_1011", 16'(bus.Q), 16'hB);
    chk("sol_1011",  16'(bus.SOL), 16'h1);
    #2 Rst_n = 1'b0;
    #1;
    chk("async_q",    16'(bus.Q),    16'h0);
    chk("async_qbar", 16'(bus.Qbar), 16'hF);
    chk("async_zero", 16'(bus.Zero), 16'h1);
    bus.En = 1'b1; bus.S = MODE_LOAD; bus.D = 4'b1111;
    tick();
    chk("edge_in_rst", 16'(bus.Q), 16'h0);
    bus.D = 4'b0110;
    Rst_n = 1'b1;
    tick();
    chk("first_edge_load", 16'(bus.Q), 16'h6);
    chk("qbar_0110",       16'(bus.Qbar), 16'h9);

    // Shift right with SIR=1 from 1001.
    load(4'b1001);
    bus.S = MODE_SHR; r_sir = 1'b1;
    exp_seq[0] = 4'b1100; exp_seq[1] = 4'b1110; exp_seq[2] = 4'b1111;
    exp_sor[0] = 1'b1; exp_sor[1] = 1'b0; exp_sor[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("shr_sor%0d", i), 16'(bus.SOR), 16'(exp_sor[i]));
      tick();
      chk($sformatf("shr_q%0d", i), 16'(bus.Q), 16'(exp_seq[i]));
    end

    // Shift left with SIL=0 from 0001; Zero only after the last edge.
    load(4'b0001);
    bus.S = MODE_SHL; bus.SIL = 1'b0;
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("shl_zero_pre%0d", i), 16'(bus.Zero), 16'h0);
      tick();
      chk($sformatf("shl_q%0d", i), 16'(bus.Q), 16'(exp_seq[i]));
    end
    chk("shl_zero_post", 16'(bus.Zero), 16'h1);

    // En low forces hold under every mode.
    load(4'b0101);
    bus.En = 1'b0; bus.D = 4'b1111; r_sir = 1'b1; bus.SIL = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.S = 2'(i);
      tick();
      chk($sformatf("en0_mode%0d", i), 16'(bus.Q), 16'h5);
    end

    // En high, S=00 holds.
    bus.En = 1'b1; bus.S = MODE_HOLD;
    tick();
    chk("hold_s00", 16'(bus.Q), 16'h5);

    // Ring counter through SOR->SIR.
    load(4'b1000);
    r_ring = 1'b1; bus.S = MODE_SHR;
    exp_seq[0] = 4'b0100; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ring_q%0d", i), 16'(bus.Q), 16'(exp_seq[i]));
    end
    r_ring = 1'b0;

    // Johnson counter through ~SOR->SIR.
    load(4'b0000);
    r_johnson = 1'b1; bus.S = MODE_SHR;
    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b1100; exp_seq[2] = 4'b1110; exp_seq[3] = 4'b1111;
    exp_seq[4] = 4'b0111; exp_seq[5] = 4'b0011; exp_seq[6] = 4'b0001; exp_seq[7] = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("johnson_q%0d", i), 16'(bus.Q), 16'(exp_seq[i]));
    end
    r_johnson = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- WIDTH-bit universal shift register built from edge-triggered master-slave D flip-flops.
- Sits directly downstream of the level-sensitive D latch: each flip-flop is a pair of latches on opposite clock phases.
- Supports hold, shift right, shift left and parallel load, selected per clock edge.
- Serves as the storage/serialisation stage for the lab datapath: serial-to-parallel capture, parallel-to-serial transmit, and ring/Johnson counters via external feedback.

Parameters:
- WIDTH, 4, register width in bits; legal range 2..16.

Ports:
- Clk  input  1  system clock; all state changes on rising edge except reset.
- Rst_n  input  1  asynchronous active-low reset.
- En  input  1  clock enable; low forces hold regardless of S.
- S  input  2  mode select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- SIR  input  1  serial input entering at MSB on shift right.
- SIL  input  1  serial input entering at LSB on shift left.
- D  input  WIDTH  parallel load data.
- Q  output  WIDTH  register contents.
- Qbar  output  WIDTH  bitwise complement of Q, always.
- SOR  output  1  serial out on right shift, equals Q[0].
- SOL  output  1  serial out on left shift, equals Q[WIDTH-1].
- Zero  output  1  high when Q is all zeros.

Behaviour:
- Reset:
  - Rst_n low clears Q to 0 immediately, with no clock required; Qbar becomes all ones, SOR=0, SOL=0, Zero=1.
  - Reset held low overrides all other inputs.
  - Rising edges while Rst_n is low are ignored.
- Reset mid-operation: any partial shift is discarded, not completed.
- Reset release: the first rising edge after Rst_n goes high acts normally per En/S. No extra dead cycle.
- Update rule, evaluated only on a Clk rising edge with Rst_n high:
  - En=0: Q holds.
  - En=1, S=00: Q holds.
  - En=1, S=01: Q[i] <= Q[i+1] for i < WIDTH-1; Q[WIDTH-1] <= SIR.
  - En=1, S=10: Q[i] <= Q[i-1] for i > 0; Q[0] <= SIL.
  - En=1, S=11: Q <= D.
- Latency: one edge; the new Q is visible immediately after the edge that samples the inputs.
- Inputs are sampled at the edge, because the master latch is transparent while Clk is low and the slave latch while Clk is high. Input changes while Clk is high do not affect Q.
- SOR, SOL, Zero and Qbar are combinational decodes of Q, with no added latency.
- Boundaries:
  - Bits shifted out (Q[0] on right shift, Q[WIDTH-1] on left shift) are lost; there is no internal wrap. Rotation is made by tying SOR to SIR, or SOL to SIL, externally.
  - A combinational loop through SIR/SIL is legal because SOR/SOL are flip-flop outputs.
  - Undefined S cannot occur; all four codes are defined.
- No X propagation after reset: every bit has a defined value.

Decomposition:
- Shared package: mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11; default WIDTH=4.
- Sub-module d_ff_ms: one master-slave D flip-flop.
  - Ports: Clk, Rst_n, D, Q, Qbar.
  - Built from two D latches, master enabled on ~Clk and slave on Clk.
  - Async active-low clear forces both latches to Q=0.
- The top level instantiates WIDTH d_ff_ms plus a 4:1 next-state mux per bit, gated by En.

Test Plan:
- Assert Rst_n=0 mid-cycle with Q=4'b1011 -> Q=0000, Qbar=1111 and Zero=1 before the next edge; release, then load D=0110 with S=11, En=1 -> Q=0110 after one edge.
- Q=1001, S=01, SIR=1, 3 edges -> Q=1100, 1110, 1111; SOR sequence 1, 0, 0 before each edge.
- Q=0001, S=10, SIL=0, 4 edges -> Q=0010, 0100, 1000, 0000; Zero rises after the 4th edge.
- Q=0101, En=0, cycle S through all modes with D=1111, SIR=1, SIL=1 for 4 edges -> Q stays 0101.
- Ring counter: SOR tied to SIR, load 1000, S=01, 4 edges -> 0100, 0010, 0001, 1000.
- Johnson counter: ~SOR fed to SIR, from 0000, 8 edges -> 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
